// File: rtl/hc_read_arbiter.sv
// Round-robin arbiter sharing one buffer read-request channel; an in-order tag FIFO steers read data back.
// Optional build macro HC_READ_ARB_FIXED_PRIORITY_EN selects lowest-index-wins priority instead of round-robin.
module hc_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUF_ID_WIDTH = 3,
  parameter int OFFSET_WIDTH = 11,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_DEPTH    = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*BUF_ID_WIDTH-1:0]   req_buffer,
  input  logic [NUM_REQ*OFFSET_WIDTH-1:0]   req_offset,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              rd_valid,
  output logic [BUF_ID_WIDTH-1:0]           rd_buffer,
  output logic [OFFSET_WIDTH-1:0]           rd_offset,
  input  logic                              rd_full,
  input  logic                              rsp_valid,
  input  logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [NUM_REQ-1:0]                out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [$clog2(TAG_DEPTH):0]        outstanding,
  output logic                              err_orphan
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]        grant_idx;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic [IDX_W-1:0]        head_tag;

  logic                    rd_valid_q,  rd_valid_d;
  logic [BUF_ID_WIDTH-1:0] rd_buffer_q, rd_buffer_d;
  logic [OFFSET_WIDTH-1:0] rd_offset_q, rd_offset_d;
  logic [NUM_REQ-1:0]      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
  logic [CNT_W-1:0]        count_q,     count_d;
  logic [PTR_W-1:0]        wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q,    rd_ptr_d;
  logic                    err_orphan_q, err_orphan_d;
  logic [IDX_W-1:0]        tag_mem [TAG_DEPTH];

  // The full check uses the pre-pop count, so a pop cannot enable a grant in the same cycle.
  assign issue = (|req_valid) && !rd_full && (count_q != CNT_W'(TAG_DEPTH));
  assign push  = issue;
  assign pop   = rsp_valid && (count_q != '0);
  assign head_tag = tag_mem[rd_ptr_q];

`ifdef HC_READ_ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) grant_idx = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    // NOTE: every variable driven here gets a default first, otherwise a latch is inferred.
    grant_idx = '0;
    cand_idx  = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rd_valid_d   = issue;
    rd_buffer_d  = rd_buffer_q;
    rd_offset_d  = rd_offset_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = '0;
    out_data_d   = out_data_q;
    err_orphan_d = err_orphan_q;

    if (issue) begin
      rd_buffer_d = req_buffer[grant_idx*BUF_ID_WIDTH +: BUF_ID_WIDTH];
      rd_offset_d = req_offset[grant_idx*OFFSET_WIDTH +: OFFSET_WIDTH];
      wr_ptr_d    = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d              = rd_ptr_q + 1'b1;
      out_valid_d[head_tag] = 1'b1;
      out_data_d            = rsp_data;
    end else if (rsp_valid) begin
      err_orphan_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q   <= 1'b0;
      rd_buffer_q  <= '0;
      rd_offset_q  <= '0;
      out_valid_q  <= '0;
      out_data_q   <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rd_valid_q   <= rd_valid_d;
      rd_buffer_q  <= rd_buffer_d;
      rd_offset_q  <= rd_offset_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // NOTE: tag storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= grant_idx;
  end

  assign rd_valid    = rd_valid_q;
  assign rd_buffer   = rd_buffer_q;
  assign rd_offset   = rd_offset_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign outstanding = count_q;
  assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_hc_read_arbiter.sv
// Directed self-checking bench for hc_read_arbiter: issue, fairness, back-pressure, FIFO full, routing, orphan/reset.
// Honors HC_READ_ARB_FIXED_PRIORITY_EN for the grant-order expectations.
module tb_hc_read_arbiter;

  localparam int N  = 4;
  localparam int BW = 3;
  localparam int OW = 11;
  localparam int DW = 512;
  localparam int TD = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*BW-1:0] req_buffer;
  logic [N*OW-1:0] req_offset;
  logic [N-1:0]    req_ready;
  logic            rd_valid;
  logic [BW-1:0]   rd_buffer;
  logic [OW-1:0]   rd_offset;
  logic            rd_full;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [N-1:0]    out_valid;
  logic [DW-1:0]   out_data;
  logic [$clog2(TD):0] outstanding;
  logic            err_orphan;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hc_read_arbiter #(
    .NUM_REQ(N), .BUF_ID_WIDTH(BW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_buffer(req_buffer), .req_offset(req_offset), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_buffer(rd_buffer), .rd_offset(rd_offset), .rd_full(rd_full),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_data(out_data),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  task automatic clear_inputs();
    req_valid  = '0;
    req_buffer = '0;
    req_offset = '0;
    rd_full    = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid: got %b want 0000", out_valid); end
    checks++; if (outstanding !== 7'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %b want 0", err_orphan); end
    checks++; if (rd_buffer !== 3'd0 || rd_offset !== 11'd0) begin errors++; $display("FAIL reset_rd_fields: got %h/%h want 0/0", rd_buffer, rd_offset); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = {16{32'hDEAD_0001}};
    reset_dut();
    req_valid = 4'b0100;
    req_buffer[2*BW +: BW] = 3'd1;
    req_offset[2*OW +: OW] = 11'h7FF;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b1 || rd_buffer !== 3'd1 || rd_offset !== 11'h7FF) begin
      errors++; $display("FAIL single_issue: got v=%b b=%0d o=%h want v=1 b=1 o=7ff", rd_valid, rd_buffer, rd_offset); end
    checks++; if (outstanding !== 7'd1) begin errors++; $display("FAIL single_outstanding: got %0d want 1", outstanding); end
    @(negedge clk);
    req_valid = '0;
    rsp_valid = 1'b1;
    rsp_data  = d;
    @(posedge clk); #1;
    checks++; if (out_valid !== 4'b0100 || out_data !== d) begin
      errors++; $display("FAIL single_response: got v=%b d=%h want v=0100 d=%h", out_valid, out_data, d); end
    checks++; if (rd_valid !== 1'b0 || outstanding !== 7'd0) begin
      errors++; $display("FAIL single_idle: got rd_valid=%b outstanding=%0d want 0/0", rd_valid, outstanding); end
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic test_fairness();
    int exp;
    reset_dut();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_buffer[i*BW +: BW] = BW'(i);
    for (int c = 0; c < 8; c++) begin
`ifdef HC_READ_ARB_FIXED_PRIORITY_EN
      exp = 0;
`else
      exp = c % N;
`endif
      #1;
      checks++; if (req_ready !== 4'(1 << exp)) begin errors++; $display("FAIL fair_ready[%0d]: got %b want grant %0d", c, req_ready, exp); end
      @(posedge clk); #1;
      checks++; if (rd_valid !== 1'b1 || rd_buffer !== BW'(exp)) begin
        errors++; $display("FAIL fair_issue[%0d]: got v=%b b=%0d want v=1 b=%0d", c, rd_valid, rd_buffer, exp); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] exp_ready;
    reset_dut();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_buffer[i*BW +: BW] = BW'(i);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first: got %b want 0001", req_ready); end
    @(posedge clk);
    @(negedge clk);
    rd_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
      @(posedge clk); #1;
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bp_rd_valid[%0d]: got %b want 0", c, rd_valid); end
      @(negedge clk);
    end
    rd_full = 1'b0;
`ifdef HC_READ_ARB_FIXED_PRIORITY_EN
    exp_ready = 4'b0001;
`else
    exp_ready = 4'b0010;
`endif
    #1;
    checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_resume_ready: got %b want %b", req_ready, exp_ready); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b1 || outstanding !== 7'd2) begin
      errors++; $display("FAIL bp_resume_issue: got v=%b out=%0d want v=1 out=2", rd_valid, outstanding); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_fifo_full();
    int bad;
    bad = 0;
    reset_dut();
    req_valid = 4'b0001;
    for (int i = 0; i < TD; i++) begin
      #1;
      if (req_ready !== 4'b0001) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_fill: got %0d missed grants want 0", bad); end
    #1;
    checks++; if (outstanding !== 7'd64) begin errors++; $display("FAIL full_count: got %0d want 64", outstanding); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_stall: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL full_rd_valid: got %b want 0", rd_valid); end
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data  = {16{32'h0000_F00D}};
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_pop_cycle: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 4'b0001 || outstanding !== 7'd63) begin
      errors++; $display("FAIL full_pop: got v=%b out=%0d want v=0001 out=63", out_valid, outstanding); end
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_regrant: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b1 || outstanding !== 7'd64) begin
      errors++; $display("FAIL full_refill: got v=%b out=%0d want v=1 out=64", rd_valid, outstanding); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_routing();
    logic [N-1:0]  seq [3];
    logic [DW-1:0] dat [3];
    seq[0] = 4'b0100; seq[1] = 4'b0001; seq[2] = 4'b1000;
    dat[0] = {16{32'hAAAA_0000}}; dat[1] = {16{32'hBBBB_1111}}; dat[2] = {16{32'hCCCC_2222}};
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      req_valid = seq[i];
      #1;
      checks++; if (req_ready !== seq[i]) begin errors++; $display("FAIL route_grant[%0d]: got %b want %b", i, req_ready, seq[i]); end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      rsp_valid = 1'b1;
      rsp_data  = dat[i];
      @(posedge clk); #1;
      checks++; if (out_valid !== seq[i] || out_data !== dat[i]) begin
        errors++; $display("FAIL route_rsp[%0d]: got v=%b d=%h want v=%b d=%h", i, out_valid, out_data, seq[i], dat[i]); end
      @(negedge clk);
    end
    rsp_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 7'd0) begin errors++; $display("FAIL route_drained: got %0d want 0", outstanding); end
  endtask

  task automatic test_orphan_reset();
    reset_dut();
    rsp_valid = 1'b1;
    rsp_data  = {16{32'h0BAD_0BAD}};
    @(posedge clk); #1;
    checks++; if (err_orphan !== 1'b1 || out_valid !== 4'b0000) begin
      errors++; $display("FAIL orphan_flag: got err=%b v=%b want err=1 v=0000", err_orphan, out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL orphan_dropped: got %h want 0", out_data); end
    @(negedge clk);
    rsp_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
    @(negedge clk);
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    checks++; if (outstanding !== 7'd3) begin errors++; $display("FAIL orphan_pending: got %0d want 3", outstanding); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (outstanding !== 7'd0 || err_orphan !== 1'b0) begin
      errors++; $display("FAIL midreset_clear: got out=%0d err=%b want 0/0", outstanding, err_orphan); end
    rsp_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (err_orphan !== 1'b1 || out_valid !== 4'b0000) begin
      errors++; $display("FAIL midreset_orphan: got err=%b v=%b want err=1 v=0000", err_orphan, out_valid); end
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_pressure();
    test_fifo_full();
    test_routing();
    test_orphan_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hc_read_arbiter.md
# hc_read_arbiter

Round-robin arbiter that shares one buffer read-request channel among `NUM_REQ` independent requesters. It sits between several stream engines and the read side of the buffer interface. Each granted request's requester index is recorded in an in-order tag FIFO, and returning read data is steered back to the originating requester. The downstream read channel returns responses in issue order.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUF_ID_WIDTH`, 3: buffer index width.
- `OFFSET_WIDTH`, 11: cache-line offset width.
- `DATA_WIDTH`, 512: read data width.
- `TAG_DEPTH`, 64: tag FIFO depth (power of two), which is also the maximum number of outstanding reads.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester read request.
- `req_buffer`  in  NUM_REQ*BUF_ID_WIDTH  buffer index; requester i occupies slice i.
- `req_offset`  in  NUM_REQ*OFFSET_WIDTH  line offset; requester i occupies slice i.
- `req_ready`  out  NUM_REQ  one-hot accept; combinational.
- `rd_valid`  out  1  downstream read request; registered.
- `rd_buffer`  out  BUF_ID_WIDTH  buffer index of the issued request.
- `rd_offset`  out  OFFSET_WIDTH  offset of the issued request.
- `rd_full`  in  1  downstream almost-full; no issue while high.
- `rsp_valid`  in  1  downstream read data valid.
- `rsp_data`  in  DATA_WIDTH  downstream read data.
- `out_valid`  out  NUM_REQ  one-hot response strobe to the requester.
- `out_data`  out  DATA_WIDTH  response data, shared by all requesters.
- `outstanding`  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy.
- `err_orphan`  out  1  sticky flag: a response arrived with no tag outstanding.

## Operation
- Issue condition, evaluated each cycle: `issue = |req_valid && !rd_full && outstanding != TAG_DEPTH`.
- Grant: the first asserted `req_valid` at or after `rr_ptr`, searching upward with wrap.
  - `req_ready[g]` is high only when `issue` holds.
  - A requester holds `req_valid` and its fields stable until it sees `req_ready`.
- On grant:
  - `rd_valid`, `rd_buffer` and `rd_offset` are registered from slice g.
  - g is pushed into the tag FIFO.
  - `rr_ptr` becomes (g+1) mod NUM_REQ.
- No grant: `rd_valid` is 0 next cycle and `rr_ptr` holds.
- Response path on `rsp_valid`:
  - Pop the tag head t.
  - Next cycle, `out_valid` is one-hot at bit t and `out_data` equals `rsp_data`.
- Orphan response (`rsp_valid` with tag FIFO empty): the data is dropped, `out_valid` stays 0, and `err_orphan` is set. It stays set until reset.
- A push and a pop in the same cycle leave `outstanding` unchanged. This also applies when the FIFO is full: the pop frees the slot, but `issue` uses the pre-pop count, so no grant is given that cycle.
- Tag FIFO pointers are log2(TAG_DEPTH) bits wide and wrap naturally. `outstanding` is a separate counter.
- Reset mid-operation clears the FIFO, the counter and `rr_ptr`. Responses still in flight after reset are treated as orphans, which is intended.

## Timing
- Reset values:
  - `rd_valid`, `out_valid`, `outstanding` and `err_orphan` are 0.
  - `rd_buffer`, `rd_offset` and `out_data` are 0.
  - `rr_ptr` is 0.
- `req_ready` responds to `req_valid` in the same cycle; no registers sit in that path.
- From grant to `rd_valid`: 1 cycle.
- From `rsp_valid` to `out_valid`: 1 cycle.
- `outstanding` updates 1 cycle after the push or pop.
- Sustained throughput: one grant per cycle while `rd_full` is low and the FIFO is not full.
- `rd_full` is sampled in the grant cycle. Because the request path is one cycle deep, the downstream almost-full threshold must absorb 1 extra request.

## Configuration
- `HC_READ_ARB_FIXED_PRIORITY_EN`
  - Defined: fixed priority. The lowest asserted index always wins, and `rr_ptr` is not implemented.
  - Undefined (default): round-robin as described above.
  - Tag FIFO, response routing and timing are identical in both builds.

## Test plan
- **Single requester:** `req_valid`=4'b0100, buffer 1, offset 11'h7FF, then `rsp_valid` with data D.
  - `req_ready`=4'b0100 in the same cycle.
  - `rd_valid`=1 with buffer 1 and offset 7FF on the next cycle.
  - `out_valid`=4'b0100 and `out_data`=D one cycle after `rsp_valid`.
- **Round-robin fairness:** all 4 requesters held valid for 8 cycles.
  - Grant order 0,1,2,3,0,1,2,3.
  - With the macro defined, the grant is 0 on all 8 cycles.
- **Back-pressure:** `rd_full`=1 for 5 cycles with all requesters valid.
  - No `req_ready` and no `rd_valid` during those cycles.
  - Issue resumes the cycle after `rd_full` drops, and `rr_ptr` is unchanged.
- **Tag FIFO full:** issue 64 requests with no responses.
  - The 65th request is stalled and `outstanding`=64.
  - One response pops the FIFO; the stalled request is granted in the following cycle.
- **Response routing:** grant sequence 2,0,3, then 3 responses A, B, C.
  - `out_valid` is 4'b0100 with A, then 4'b0001 with B, then 4'b1000 with C.
- **Orphan and reset:** `rsp_valid` with an empty FIFO.
  - `err_orphan`=1 and `out_valid`=0.
  - Assert `reset` for 1 cycle with 3 requests outstanding: `outstanding`=0 and `err_orphan`=0 on the cycle after reset.
